// File: rtl/count15_timer_ctrl.sv
// Programmable-period tick timer around a WIDTH-bit up-counter with one-shot/periodic
// modes, start/pause/stop control and a config handshake accepted only while not counting.
module count15_timer_ctrl #(
    parameter int WIDTH          = 4,
    parameter int DEFAULT_PERIOD = 15,
    parameter bit DEFAULT_MODE   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       state,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [7:0]       tick_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] period_reg, period_d;
    logic             mode_reg, mode_d;
    logic             tick_q, tick_d;
    logic [7:0]       tick_cnt_q, tick_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            q_q        <= '0;
            period_reg <= WIDTH'(DEFAULT_PERIOD);
            mode_reg   <= DEFAULT_MODE;
            tick_q     <= 1'b0;
            tick_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            period_reg <= period_d;
            mode_reg   <= mode_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Priority is stop > start > pause; a start while running just keeps counting
    // but still masks a simultaneous pause.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        period_d   = period_reg;
        mode_d     = mode_reg;
        tick_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;

        if (cfg_valid && cfg_ready) begin
            period_d = cfg_period;
            mode_d   = cfg_mode;
        end

        case (state_q)
            IDLE: begin
                if (stop) begin
                    q_d = '0;
                end else if (start) begin
                    state_d    = RUN;
                    q_d        = '0;
                    tick_cnt_d = 8'd0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else if (!start && pause) begin
                    state_d = PAUSED;
                end else if (q_q == period_reg) begin
                    q_d        = '0;
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_q + 8'd1;
                    if (!mode_reg) begin
                        state_d = DONE;
                    end
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end
            PAUSED: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else if (start) begin
                    state_d    = RUN;
                    q_d        = '0;
                    tick_cnt_d = 8'd0;
                end
            end
        endcase
    end

    assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == PAUSED);
    assign done      = (state_q == DONE);
    assign state     = state_q;
    assign q         = q_q;
    assign tick      = tick_q;
    assign tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_count15_timer_ctrl.sv
// Directed checks of count15_timer_ctrl with hand-computed values, followed by a
// randomized control phase compared against a small behavioural model.
module tb_count15_timer_ctrl;

    logic       clk;
    logic       reset_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_period;
    logic       cfg_mode;
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] q;
    logic [1:0] state;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] tick_cnt;

    int total = 0;
    int bad   = 0;

    logic [1:0] m_state;
    logic [3:0] m_q;
    logic [3:0] m_period;
    logic       m_mode;
    logic       m_tick;
    logic [7:0] m_tick_cnt;

    count15_timer_ctrl #(.WIDTH(4), .DEFAULT_PERIOD(15), .DEFAULT_MODE(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .q          (q),
        .state      (state),
        .busy       (busy),
        .tick       (tick),
        .done       (done),
        .tick_cnt   (tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, advances the reference model, and waits past the edge.
    task automatic applyStimulus(input logic rn, input logic cv, input logic [3:0] cp,
                                 input logic cm, input logic st, input logic pa,
                                 input logic sp);
        logic ok;
        reset_n = rn; cfg_valid = cv; cfg_period = cp; cfg_mode = cm;
        start = st; pause = pa; stop = sp;
        if (!rn) begin
            m_state = 2'd0; m_q = 4'd0; m_period = 4'd15; m_mode = 1'b1;
            m_tick = 1'b0; m_tick_cnt = 8'd0;
        end else begin
            ok = cv && (m_state == 2'd0 || m_state == 2'd3);
            m_tick = 1'b0;
            if (sp) begin
                m_state = 2'd0; m_q = 4'd0;
            end else if (m_state == 2'd1) begin
                if (pa && !st) m_state = 2'd2;
                else if (m_q != m_period) m_q = m_q + 4'd1;
                else begin
                    m_q = 4'd0; m_tick = 1'b1; m_tick_cnt = m_tick_cnt + 8'd1;
                    if (!m_mode) m_state = 2'd3;
                end
            end else if (st) begin
                if (m_state != 2'd2) begin
                    m_q = 4'd0; m_tick_cnt = 8'd0;
                end
                m_state = 2'd1;
            end
            if (ok) begin
                m_period = cp; m_mode = cm;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_period = 4'd0; cfg_mode = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        @(negedge clk);

        $display("[TB] reset and default periodic run");
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", 8'(state), 8'd0);
        checkOutput("rst_q", 8'(q), 8'd0);
        checkOutput("rst_tick", 8'(tick), 8'd0);
        checkOutput("rst_tick_cnt", tick_cnt, 8'd0);
        checkOutput("rst_cfg_ready", 8'(cfg_ready), 8'd1);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_done", 8'(done), 8'd0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_state_run", 8'(state), 8'd1);
        checkOutput("t1_q0", 8'(q), 8'd0);
        checkOutput("t1_busy", 8'(busy), 8'd1);
        for (int k = 1; k <= 15; k++) begin
            idle(1);
            checkOutput("t1_q_ramp", 8'(q), 8'(k));
            checkOutput("t1_no_tick", 8'(tick), 8'd0);
        end
        idle(1);
        checkOutput("t1_wrap_q", 8'(q), 8'd0);
        checkOutput("t1_tick1", 8'(tick), 8'd1);
        checkOutput("t1_tick_cnt1", tick_cnt, 8'd1);
        idle(1);
        checkOutput("t1_tick_pulse", 8'(tick), 8'd0);
        checkOutput("t1_q_after", 8'(q), 8'd1);
        idle(15);
        checkOutput("t1_tick2", 8'(tick), 8'd1);
        checkOutput("t1_tick_cnt2", tick_cnt, 8'd2);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_stop_state", 8'(state), 8'd0);
        checkOutput("t1_stop_cnt_hold", tick_cnt, 8'd2);

        $display("[TB] one-shot P=3");
        applyStimulus(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_cnt_clear", tick_cnt, 8'd0);
        idle(3);
        checkOutput("t2_q3", 8'(q), 8'd3);
        idle(1);
        checkOutput("t2_tick", 8'(tick), 8'd1);
        checkOutput("t2_state_done", 8'(state), 8'd3);
        checkOutput("t2_done", 8'(done), 8'd1);
        checkOutput("t2_q0", 8'(q), 8'd0);
        checkOutput("t2_cfg_ready", 8'(cfg_ready), 8'd1);
        checkOutput("t2_tick_cnt", tick_cnt, 8'd1);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_pause_ignored", 8'(state), 8'd3);
        checkOutput("t2_tick_off", 8'(tick), 8'd0);

        $display("[TB] pause and resume with P=5");
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        checkOutput("t3_q2", 8'(q), 8'd2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("t3_paused", 8'(state), 8'd2);
            checkOutput("t3_q_hold", 8'(q), 8'd2);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_resume_state", 8'(state), 8'd1);
        checkOutput("t3_resume_q", 8'(q), 8'd2);
        idle(3);
        checkOutput("t3_q5", 8'(q), 8'd5);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_pause_at_tc", 8'(tick), 8'd0);
        checkOutput("t3_pause_at_tc_q", 8'(q), 8'd5);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("t3_tick", 8'(tick), 8'd1);
        checkOutput("t3_q_wrap", 8'(q), 8'd0);
        checkOutput("t3_tick_cnt", tick_cnt, 8'd1);

        $display("[TB] config while running, then stop");
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_cfg_ready_run", 8'(cfg_ready), 8'd0);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkOutput("t4_q5", 8'(q), 8'd5);
        idle(1);
        checkOutput("t4_period_kept", 8'(tick), 8'd1);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_stop_state", 8'(state), 8'd0);
        checkOutput("t4_stop_q", 8'(q), 8'd0);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(7);
        checkOutput("t4_q7", 8'(q), 8'd7);
        idle(1);
        checkOutput("t4_new_period_tick", 8'(tick), 8'd1);

        $display("[TB] period zero");
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            idle(1);
            checkOutput("t5_tick_every", 8'(tick), 8'd1);
            checkOutput("t5_q_zero", 8'(q), 8'd0);
            checkOutput("t5_tick_cnt", tick_cnt, 8'(k));
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t5_all_ctl_state", 8'(state), 8'd0);
        checkOutput("t5_all_ctl_tick", 8'(tick), 8'd0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("t5_oneshot_tick", 8'(tick), 8'd1);
        checkOutput("t5_oneshot_done", 8'(state), 8'd3);

        $display("[TB] reset mid-run and random control");
        applyStimulus(1'b1, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(9);
        checkOutput("t6_q9", 8'(q), 8'd9);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_rst_state", 8'(state), 8'd0);
        checkOutput("t6_rst_q", 8'(q), 8'd0);
        checkOutput("t6_rst_tick_cnt", tick_cnt, 8'd0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(15);
        checkOutput("t6_default_q15", 8'(q), 8'd15);
        idle(1);
        checkOutput("t6_default_tick", 8'(tick), 8'd1);
        checkOutput("t6_default_periodic", 8'(state), 8'd1);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1, ($urandom_range(7) == 0), 4'($urandom_range(15)),
                          1'($urandom_range(1)), ($urandom_range(7) == 0),
                          ($urandom_range(7) == 0), ($urandom_range(31) == 0));
            checkOutput("rnd_state", 8'(state), 8'(m_state));
            checkOutput("rnd_q", 8'(q), 8'(m_q));
            checkOutput("rnd_tick", 8'(tick), 8'(m_tick));
            checkOutput("rnd_tick_cnt", tick_cnt, m_tick_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count15_timer_ctrl.md
Name: count15_timer_ctrl

Overview:
Sequencing controller for the 4-bit up-counter datapath (0..15 with wrap). Adds a programmable terminal count, one-shot/periodic modes, start/pause/stop control and a config handshake. The counter is embedded and exposed on q. Sits between software-visible control registers and logic that consumes timer ticks.

Parameters:
WIDTH, 4, counter and period width in bits.
DEFAULT_PERIOD, 15, period_reg value after reset (0..2^WIDTH-1).
DEFAULT_MODE, 1, mode_reg after reset (0 = one-shot, 1 = periodic).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous, active-low reset.
cfg_valid  in  1  config request.
cfg_ready  out  1  config accepted this cycle when cfg_valid=1.
cfg_period  in  WIDTH  new terminal count.
cfg_mode  in  1  new mode.
start  in  1  start or resume.
pause  in  1  pause the counter.
stop  in  1  abort to IDLE.
q  out  WIDTH  current count.
state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.
busy  out  1  state is RUN or PAUSED.
tick  out  1  one-cycle pulse, registered, on terminal count.
done  out  1  level; high while in DONE.
tick_cnt  out  8  number of ticks since the last start from IDLE/DONE; wraps 255->0.

Behaviour:
- Reset (reset_n=0 at an edge, from any state, mid-run included): state=IDLE, q=0, tick=0, tick_cnt=0, period_reg=DEFAULT_PERIOD, mode_reg=DEFAULT_MODE. All outputs valid on the first edge after reset asserts.
- cfg_ready = (state==IDLE or DONE); combinational. Handshake completes when cfg_valid&&cfg_ready: period_reg<=cfg_period, mode_reg<=cfg_mode next edge. In RUN/PAUSED cfg_ready=0; cfg_valid is ignored and must be held by the requester.
- Control priority per edge: stop > start > pause. Lower-priority inputs in the same cycle are ignored.
- IDLE: start -> RUN, q<=0, tick_cnt<=0. Config and start in the same cycle: the run uses the new period/mode (config register write and q clear happen on the same edge; the first terminal compare uses the new period).
- RUN: if q==period_reg: q<=0, tick<=1, tick_cnt<=tick_cnt+1. Then if mode_reg=0 -> DONE, else stay RUN. Otherwise q<=q+1 (WIDTH-bit, wraps only via the compare). pause -> PAUSED, q holds, and no tick is issued even if q==period_reg that cycle.
- PAUSED: q and tick_cnt hold, tick=0. start -> RUN; counting resumes from the held q on the next edge.
- DONE: q=0, done=1. start -> RUN (q<=0, tick_cnt<=0). pause is ignored.
- stop in any state -> IDLE, q<=0, tick<=0. tick_cnt holds its value.
- period_reg=0 in periodic mode: tick on every RUN cycle, q stays 0. In one-shot mode: tick one cycle after start, then DONE.
- Tick timing: with period P and start sampled at edge E0, the first tick is high in the cycle after edge E0+P+1. The period is then P+1 cycles.
- tick is 0 in every state except the cycle following a terminal-count edge in RUN.
- busy and done are decoded combinationally from state.

Test Plan:
1. Reset, then start with defaults (P=15, periodic) for 40 cycles -> q runs 0..15,0..; tick pulses every 16 cycles; tick_cnt=2 after 33 cycles of RUN.
2. Config P=3, mode one-shot, then start -> q 0,1,2,3; tick for one cycle; state=DONE, done=1, q=0, cfg_ready=1, tick_cnt=1.
3. Config P=5 periodic, run to q=2, assert pause for 4 cycles, then start -> q holds at 2 while state=PAUSED; resumes 3,4,5; tick; q=0.
4. cfg_valid with P=7 while in RUN -> cfg_ready=0 and period unchanged. Then assert stop -> IDLE, q=0; config is accepted on the next cycle.
5. Periodic with P=0 -> tick high every cycle and q=0. Assert stop, start and pause together -> IDLE.
6. reset_n=0 while in RUN at q=9 -> next edge: state=IDLE, q=0, period=15, mode periodic, tick_cnt=0. Drive random start/stop/pause for 400 cycles and compare against a reference model.
